// File: rtl/branch_predictor_bht_if.sv
// IF/EX-side signal bundle of the two-bit branch history table.
// The pipeline drives through master; the predictor answers through slave.
interface branch_predictor_bht_if #(
   parameter int DATA_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int IDX_BITS   = 6,
   parameter int STAT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] if_pc;
   logic [INST_WIDTH-1:0] if_ir;
   logic                  if_predict_taken;
   logic [DATA_WIDTH-1:0] if_predict_target;
   logic [IDX_BITS-1:0]   if_bht_index;
   logic                  ex_update_valid;
   logic [IDX_BITS-1:0]   ex_bht_index;
   logic                  ex_taken;
   logic                  ex_mispredict;
   logic [STAT_WIDTH-1:0] stat_branches;
   logic [STAT_WIDTH-1:0] stat_mispredicts;

   modport master (
      output if_pc, if_ir, ex_update_valid, ex_bht_index, ex_taken, ex_mispredict,
      input  if_predict_taken, if_predict_target, if_bht_index,
             stat_branches, stat_mispredicts
   );

   modport slave (
      input  if_pc, if_ir, ex_update_valid, ex_bht_index, ex_taken, ex_mispredict,
      output if_predict_taken, if_predict_target, if_bht_index,
             stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor_bht.sv
// Two-bit saturating-counter BHT: zero-latency IF prediction/target, EX-side training, stats.
// Optional gshare indexing (global history XOR PC) is enabled by defining BP_GSHARE_EN.
module branch_predictor_bht #(
   parameter int RISC_V_DATA_WIDTH = 32,
   parameter int INST_WIDTH        = 32,
   parameter int IDX_BITS          = 6,
   parameter int HIST_BITS         = 6,
   parameter int STAT_WIDTH        = 16
) (
   input logic                  clk,
   input logic                  rst,
   branch_predictor_bht_if.slave bus
);

   localparam int BHT_DEPTH = 1 << IDX_BITS;

   logic [BHT_DEPTH-1:0][1:0]      bht;
   logic                           is_branch;
   logic [IDX_BITS-1:0]            pc_idx;
   logic [IDX_BITS-1:0]            rd_idx;
   logic [1:0]                     ctr_cur;
   logic [1:0]                     ctr_next;
   logic [RISC_V_DATA_WIDTH-1:0]   b_imm;
   logic [STAT_WIDTH-1:0]          branches;
   logic [STAT_WIDTH-1:0]          mispredicts;
   logic                           unused_ir;

   assign is_branch = (bus.if_ir[6:0] == 7'b1100011);
   assign pc_idx    = bus.if_pc[IDX_BITS+1:2];
   assign unused_ir = ^bus.if_ir[24:12];

`ifdef BP_GSHARE_EN
   logic [HIST_BITS-1:0] ghr;

   assign rd_idx = pc_idx ^ IDX_BITS'(ghr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ghr <= '0;
      else if (bus.ex_update_valid)
         ghr <= {ghr[HIST_BITS-2:0], bus.ex_taken};
   end
`else
   assign rd_idx = pc_idx;
`endif

   // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended
   assign b_imm = {{(RISC_V_DATA_WIDTH-13){bus.if_ir[31]}},
                   bus.if_ir[31], bus.if_ir[7], bus.if_ir[30:25], bus.if_ir[11:8], 1'b0};

   assign bus.if_bht_index      = rd_idx;
   assign bus.if_predict_taken  = is_branch & bht[rd_idx][1];
   assign bus.if_predict_target = bus.if_pc + b_imm;

   assign ctr_cur = bht[bus.ex_bht_index];

   always_comb begin
      ctr_next = ctr_cur;
      if (bus.ex_taken) begin
         if (ctr_cur != 2'b11)
            ctr_next = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00)
            ctr_next = ctr_cur - 2'd1;
      end
   end

   // Reads are combinational off the registered table, so a same-cycle hit sees the old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bht <= {BHT_DEPTH{2'b01}};
      else if (bus.ex_update_valid)
         bht[bus.ex_bht_index] <= ctr_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branches    <= '0;
         mispredicts <= '0;
      end else if (bus.ex_update_valid) begin
         if (branches != '1)
            branches <= branches + 1'b1;
         if (bus.ex_mispredict && (mispredicts != '1))
            mispredicts <= mispredicts + 1'b1;
      end
   end

   assign bus.stat_branches    = branches;
   assign bus.stat_mispredicts = mispredicts;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: prediction, training, collision, stats, reset.
// Gshare-specific vectors build only when BP_GSHARE_EN is defined.
module tb_branch_predictor_bht;

   localparam logic [31:0] IR_BEQ_M8   = 32'hFE000CE3;
   localparam logic [31:0] IR_BEQ_P16  = 32'h00000863;
   localparam logic [31:0] IR_BEQ_P2K  = 32'h000000E3;
   localparam logic [31:0] IR_ADD      = 32'hFE000CB3;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [5:0] ghr_m;

   branch_predictor_bht_if #(.DATA_WIDTH(32), .INST_WIDTH(32), .IDX_BITS(6), .STAT_WIDTH(16)) bus ();

   branch_predictor_bht #(
      .RISC_V_DATA_WIDTH(32), .INST_WIDTH(32), .IDX_BITS(6), .HIST_BITS(6), .STAT_WIDTH(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pc_for(input logic [5:0] idx);
      logic [5:0] raw;
`ifdef BP_GSHARE_EN
      raw = idx ^ ghr_m;
`else
      raw = idx;
`endif
      return {24'd0, raw, 2'b00};
   endfunction

   // Called right after a negedge: drives a branch for idx and settles the comb outputs
   task automatic look(input logic [5:0] idx, input logic [31:0] ir);
      bus.if_pc = pc_for(idx);
      bus.if_ir = ir;
      #1;
   endtask

   task automatic upd(input logic [5:0] idx, input logic taken, input logic misp);
      bus.ex_update_valid = 1'b1;
      bus.ex_bht_index    = idx;
      bus.ex_taken        = taken;
      bus.ex_mispredict   = misp;
      @(posedge clk);
      ghr_m = {ghr_m[4:0], taken};
      @(negedge clk);
      bus.ex_update_valid = 1'b0;
      bus.ex_mispredict   = 1'b0;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      ghr_m = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ghr_m  = '0;
      rst    = 1'b1;
      bus.if_pc = '0;
      bus.if_ir = '0;
      bus.ex_update_valid = 1'b0;
      bus.ex_bht_index    = '0;
      bus.ex_taken        = 1'b0;
      bus.ex_mispredict   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state and plain decode
      bus.if_pc = 32'h40; bus.if_ir = IR_BEQ_M8; #1;
      chk("rst_pred",     64'(bus.if_predict_taken), 64'd0);
      chk("rst_idx",      64'(bus.if_bht_index), 64'd16);
      chk("rst_branches", 64'(bus.stat_branches), 64'd0);
      chk("rst_misp",     64'(bus.stat_mispredicts), 64'd0);
      chk("tgt_m8",       64'(bus.if_predict_target), 64'h38);
      bus.if_pc = 32'h0; #1;
      chk("tgt_wrap",     64'(bus.if_predict_target), 64'hFFFF_FFF8);
      bus.if_pc = 32'h100; bus.if_ir = IR_BEQ_P16; #1;
      chk("tgt_p16",      64'(bus.if_predict_target), 64'h110);
      bus.if_pc = 32'h1000; bus.if_ir = IR_BEQ_P2K; #1;
      chk("tgt_p2k",      64'(bus.if_predict_target), 64'h1800);
      bus.if_pc = 32'h1040; #1;
      chk("idx_hi_pc",    64'(bus.if_bht_index), 64'd16);
      bus.if_pc = 32'hFC; #1;
      chk("idx_max",      64'(bus.if_bht_index), 64'd63);
      @(negedge clk);

      // train up idx16 to saturation
      upd(6'd16, 1'b1, 1'b1); look(6'd16, IR_BEQ_M8);
      chk("up1_pred", 64'(bus.if_predict_taken), 64'd1);
      chk("up1_idx",  64'(bus.if_bht_index), 64'd16);
      upd(6'd16, 1'b1, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("up2_pred", 64'(bus.if_predict_taken), 64'd1);
      upd(6'd16, 1'b1, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("up3_pred", 64'(bus.if_predict_taken), 64'd1);
      look(6'd16, IR_ADD);
      chk("nonbranch_pred", 64'(bus.if_predict_taken), 64'd0);
      look(6'd17, IR_BEQ_M8);
      chk("neighbour_pred", 64'(bus.if_predict_taken), 64'd0);

      // train down: 11->10->01->00->00, then back up 00->01->10
      upd(6'd16, 1'b0, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("dn1_pred", 64'(bus.if_predict_taken), 64'd1);
      upd(6'd16, 1'b0, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("dn2_pred", 64'(bus.if_predict_taken), 64'd0);
      upd(6'd16, 1'b0, 1'b0);
      upd(6'd16, 1'b0, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("dn4_pred", 64'(bus.if_predict_taken), 64'd0);
      upd(6'd16, 1'b1, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("re1_pred", 64'(bus.if_predict_taken), 64'd0);
      upd(6'd16, 1'b1, 1'b0); look(6'd16, IR_BEQ_M8);
      chk("re2_pred", 64'(bus.if_predict_taken), 64'd1);
      chk("st_branches", 64'(bus.stat_branches), 64'd9);
      chk("st_misp",     64'(bus.stat_mispredicts), 64'd1);

      // mispredict without valid is ignored
      bus.ex_mispredict = 1'b1;
      @(negedge clk); #1;
      bus.ex_mispredict = 1'b0;
      chk("novalid_branches", 64'(bus.stat_branches), 64'd9);
      chk("novalid_misp",     64'(bus.stat_mispredicts), 64'd1);

      // same-cycle read/update collision on idx5 (starts at 01)
      bus.ex_update_valid = 1'b1;
      bus.ex_bht_index    = 6'd5;
      bus.ex_taken        = 1'b1;
      bus.ex_mispredict   = 1'b0;
      look(6'd5, IR_BEQ_M8);
      chk("coll_same_cycle", 64'(bus.if_predict_taken), 64'd0);
      @(posedge clk);
      ghr_m = {ghr_m[4:0], 1'b1};
      @(negedge clk);
      bus.ex_update_valid = 1'b0;
      look(6'd5, IR_BEQ_M8);
      chk("coll_next_cycle", 64'(bus.if_predict_taken), 64'd1);

      // statistics saturation, then async reset mid-stream
      bus.ex_update_valid = 1'b1;
      bus.ex_bht_index    = 6'd30;
      bus.ex_taken        = 1'b1;
      bus.ex_mispredict   = 1'b1;
      repeat (65540) @(posedge clk);
      @(negedge clk); #1;
      chk("sat_branches", 64'(bus.stat_branches), 64'hFFFF);
      chk("sat_misp",     64'(bus.stat_mispredicts), 64'hFFFF);
      #2;
      rst = 1'b1;
      ghr_m = '0;
      #1;
      chk("arst_branches", 64'(bus.stat_branches), 64'd0);
      chk("arst_misp",     64'(bus.stat_mispredicts), 64'd0);
      bus.ex_update_valid = 1'b0;
      bus.ex_mispredict   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      look(6'd16, IR_BEQ_M8);
      chk("arst_pred16", 64'(bus.if_predict_taken), 64'd0);
      look(6'd5, IR_BEQ_M8);
      chk("arst_pred5",  64'(bus.if_predict_taken), 64'd0);
      look(6'd30, IR_BEQ_M8);
      chk("arst_pred30", 64'(bus.if_predict_taken), 64'd0);
      // one taken from the 01 reset value is enough to flip to taken
      upd(6'd30, 1'b1, 1'b0); look(6'd30, IR_BEQ_M8);
      chk("arst_one_up", 64'(bus.if_predict_taken), 64'd1);

`ifdef BP_GSHARE_EN
      pulse_rst();
      upd(6'd0, 1'b1, 1'b0);
      upd(6'd0, 1'b1, 1'b0);
      bus.if_pc = 32'h40; bus.if_ir = IR_BEQ_M8; #1;
      chk("gshare_idx", 64'(bus.if_bht_index), 64'd19);
      chk("gshare_pred", 64'(bus.if_predict_taken), 64'd0);
`else
      pulse_rst();
      upd(6'd0, 1'b1, 1'b0);
      upd(6'd0, 1'b1, 1'b0);
      bus.if_pc = 32'h40; bus.if_ir = IR_BEQ_M8; #1;
      chk("pc_only_idx", 64'(bus.if_bht_index), 64'd16);
      chk("pc_only_pred", 64'(bus.if_predict_taken), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
